param_universal_shifter: RTL and testbench
==========================================

PARAM_UNIVERSAL_SHIFTER -- requirements
Module: param_universal_shifter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: register width in bits; legal values are 2 and above.
REQ-002 SHALL provide parameter CNT_W, default 4: width of the shift-count field; the maximum count is 2^CNT_W-1.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port cmd_valid_i, input, 1 bit: command request.
REQ-006 SHALL provide port cmd_ready_o, output, 1 bit: block can accept a command.
REQ-007 SHALL provide port mode_i, input, 3 bits: operation opcode.
REQ-008 SHALL provide port count_i, input, CNT_W bits: number of single-bit shift steps.
REQ-009 SHALL provide port data_i, input, WIDTH bits: parallel load data.
REQ-010 SHALL provide port sin_lsb_i, input, 1 bit: serial bit entering bit 0 on a left shift.
REQ-011 SHALL provide port sin_msb_i, input, 1 bit: serial bit entering bit WIDTH-1 on a logical right shift.
REQ-012 SHALL provide port data_o, output, WIDTH bits: register contents.
REQ-013 SHALL provide ports sout_msb_o and sout_lsb_o, output, 1 bit each: equal to data_o[WIDTH-1] and data_o[0].
REQ-014 SHALL provide port busy_o, output, 1 bit: a multi-step shift is in progress.
REQ-015 SHALL provide port done_o, output, 1 bit: one-cycle command-complete pulse.

Function
REQ-016 SHALL implement two states, IDLE and SHIFT; cmd_ready_o = (state==IDLE), busy_o = (state==SHIFT).
REQ-017 SHALL accept a command on a rising edge where cmd_valid_i and cmd_ready_o are both high; cmd_valid_i is ignored while busy_o is high.
REQ-018 SHALL decode opcodes as follows: 000 hold, 001 load, 010 shift left, 011 logical shift right, 100 arithmetic shift right, 101 rotate left, 110 rotate right, 111 reserved (treated as hold).
REQ-019 SHALL, for hold or load, complete on the accept edge: load writes data_i to data_o and hold leaves data_o unchanged; done_o is high in the following cycle, and the state stays IDLE.
REQ-020 SHALL, for a shift or rotate opcode with count_i = 0, leave data_o unchanged and assert done_o in the following cycle, staying in IDLE.
REQ-021 SHALL, for a shift or rotate opcode with count_i = n > 0, latch the mode and n on the accept edge and enter SHIFT; the register does not change on the accept edge.
REQ-022 SHALL, in SHIFT, perform exactly one step per cycle for n cycles, sampling the serial inputs on each step edge; after the n-th step, return to IDLE with done_o high for the next cycle only.
REQ-023 SHALL define the steps as follows:
  - left: {d[W-2:0], sin_lsb_i}
  - logical right: {sin_msb_i, d[W-1:1]}
  - arithmetic right: {d[W-1], d[W-1:1]}
  - rotate left: {d[W-2:0], d[W-1]}
  - rotate right: {d[0], d[W-1:1]}
REQ-024 SHALL allow back-to-back commands: a command presented in the cycle in which done_o is high is accepted.
REQ-025 SHALL ignore data_i and count_i after the accept edge; changes to them mid-shift have no effect.

Reset
REQ-026 SHALL, when rst is high at a rising edge, set data_o=0, state=IDLE, busy_o=0, done_o=0 and the remaining count to 0.
REQ-027 SHALL give rst priority over cmd_valid_i; a command presented during reset is not accepted.
REQ-028 SHALL, on reset during SHIFT, abort the operation with no done_o pulse; cmd_ready_o is 1 in the first cycle after reset.

Configuration
REQ-029 SHALL, when macro SHIFTER_ROTATE_EN is defined, implement opcodes 101 and 110 as rotates per REQ-023.
REQ-030 SHALL, when SHIFTER_ROTATE_EN is undefined, treat opcodes 101 and 110 as hold per REQ-019 (no SHIFT entry, done_o in the next cycle) and synthesise no rotate logic.

Verification
REQ-031 SHALL cover: reset, then load 0xA5 -> data_o=0xA5 and done_o=1 for exactly one cycle after the accept edge; busy_o stays 0.
REQ-032 SHALL cover: load 0x81, then shift left count 3 with sin_lsb_i=1 -> data_o steps 0x03, 0x07, 0x0F; busy_o=1 for 3 cycles; cmd_ready_o=0 meanwhile; done_o pulses once.
REQ-033 SHALL cover: load 0x80, then arithmetic right count 2 -> 0xE0; load 0x80, then logical right count 2 with sin_msb_i=0 -> 0x20.
REQ-034 SHALL cover: load 0x01, then opcode 110 count 1 -> 0x80 with SHIFTER_ROTATE_EN defined; without the macro -> data_o stays 0x01 and done_o follows in the next cycle.
REQ-035 SHALL cover: load 0xFF, shift left count 5 with sin_lsb_i=0, rst asserted after 2 steps -> data_o=0x00, no done_o pulse, cmd_ready_o=1 in the following cycle.
REQ-036 SHALL cover: shift count 0 -> data_o unchanged and done_o in the next cycle; cmd_valid_i held high during a count-4 shift -> only the first command executes, and the next is accepted in the cycle done_o is high.

Source files
------------

// File: rtl/param_universal_shifter.sv
// Universal shift register: hold/load/shift/arith-shift with a multi-cycle step engine.
// Optional rotate opcodes are enabled by defining SHIFTER_ROTATE_EN.
module param_universal_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       mode_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             sin_lsb_i,
  input  logic             sin_msb_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
  logic             shift_op;
  op_t              mode_in;

  assign mode_in = op_t'(mode_i);

  // Opcodes that need the step engine; everything else completes on the accept edge.
  always_comb begin
    shift_op = 1'b0;
    case (mode_in)
      OP_SHL, OP_LSR, OP_ASR: shift_op = 1'b1;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:         shift_op = 1'b1;
`endif
      default:                shift_op = 1'b0;
    endcase
  end

  always_comb begin
    step_val = data_q;
    case (mode_q)
      OP_SHL:  step_val = {data_q[WIDTH-2:0], sin_lsb_i};
      OP_LSR:  step_val = {sin_msb_i, data_q[WIDTH-1:1]};
      OP_ASR:  step_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SHIFTER_ROTATE_EN
      OP_ROL:  step_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      OP_ROR:  step_val = {data_q[0], data_q[WIDTH-1:1]};
`endif
      default: step_val = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (shift_op && (count_i != '0)) begin
            state_d = SHIFT;
            mode_d  = mode_in;
            cnt_d   = count_i;
          end else begin
            done_d = 1'b1;
            if (mode_in == OP_LOAD) data_d = data_i;
          end
        end
      end
      SHIFT: begin
        data_d = step_val;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= OP_HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign data_o      = data_q;
  assign sout_msb_o  = data_q[WIDTH-1];
  assign sout_lsb_o  = data_q[0];
  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == SHIFT);
  assign done_o      = done_q;

endmodule

// File: tb/tb_param_universal_shifter.sv
// Self-checking bench: cycle-level behavioural model plus directed literal scenarios and random traffic.
module tb_param_universal_shifter;

  localparam int W = 8;
  localparam int CW = 4;
  localparam int unsigned MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    mode = '0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  data_in = '0;
  logic          sin_lsb = 1'b0;
  logic          sin_msb = 1'b0;
  logic [W-1:0]  data_out;
  logic          sout_msb, sout_lsb, busy, done;

  int checks = 0;
  int errors = 0;

  int unsigned m_data = 0;
  int unsigned m_rem  = 0;
  int unsigned m_op   = 0;
  bit          m_done = 1'b0;

  param_universal_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .mode_i      (mode),
    .count_i     (count),
    .data_i      (data_in),
    .sin_lsb_i   (sin_lsb),
    .sin_msb_i   (sin_msb),
    .data_o      (data_out),
    .sout_msb_o  (sout_msb),
    .sout_lsb_o  (sout_lsb),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  function automatic bit needs_steps(input int unsigned op);
`ifdef SHIFTER_ROTATE_EN
    return (op >= 2) && (op <= 6);
`else
    return (op >= 2) && (op <= 4);
`endif
  endfunction

  function automatic int unsigned step(input int unsigned d, input int unsigned op,
                                       input int unsigned sl, input int unsigned sm);
    case (op)
      2: return ((d << 1) | sl) & MASK;
      3: return (d >> 1) | (sm << (W - 1));
      4: return (d >> 1) | (d & (1 << (W - 1)));
      5: return ((d << 1) | (d >> (W - 1))) & MASK;
      6: return (d >> 1) | ((d & 1) << (W - 1));
      default: return d;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_data = 0; m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_data = step(m_data, m_op, sin_lsb, sin_msb);
      m_rem--;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (cmd_valid) begin
        if (needs_steps(mode) && count != 0) begin
          m_op = mode; m_rem = count;
        end else begin
          m_done = 1'b1;
          if (mode == 3'd1) m_data = data_in;
        end
      end
    end
    @(negedge clk);
    check("data_o",     data_out, m_data);
    check("sout_msb_o", sout_msb, (m_data >> (W - 1)) & 1);
    check("sout_lsb_o", sout_lsb, m_data & 1);
    check("busy_o",     busy, m_rem > 0);
    check("cmd_ready_o", cmd_ready, m_rem == 0);
    check("done_o",     done, m_done);
  endtask

  task automatic issue(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] d);
    cmd_valid = 1'b1; mode = op; count = cnt; data_in = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_data", data_out, 8'h00);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    issue(3'd1, 0, 8'hA5);
    check("loadA5_data", data_out, 8'hA5);
    check("loadA5_done", done, 1);
    check("loadA5_busy", busy, 0);
    tick();
    check("loadA5_done_off", done, 0);

    issue(3'd1, 0, 8'h81);
    sin_lsb = 1'b1;
    issue(3'd2, 3, 8'h00);
    check("shl_accept_data", data_out, 8'h81);
    check("shl_accept_busy", busy, 1);
    check("shl_accept_ready", cmd_ready, 0);
    tick(); check("shl_step1", data_out, 8'h03); check("shl_busy1", busy, 1);
    tick(); check("shl_step2", data_out, 8'h07); check("shl_busy2", busy, 1);
    tick(); check("shl_step3", data_out, 8'h0F); check("shl_done", done, 1);
    check("shl_busy_end", busy, 0);
    tick(); check("shl_done_off", done, 0);

    issue(3'd1, 0, 8'h80);
    issue(3'd4, 2, 8'h00);
    tick(); tick();
    check("asr_result", data_out, 8'hE0);
    sin_msb = 1'b0;
    issue(3'd1, 0, 8'h80);
    issue(3'd3, 2, 8'h00);
    tick(); tick();
    check("lsr_result", data_out, 8'h20);

    issue(3'd1, 0, 8'h01);
    issue(3'd6, 1, 8'h00);
`ifdef SHIFTER_ROTATE_EN
    check("ror_busy", busy, 1);
    tick();
    check("ror_result", data_out, 8'h80);
    check("ror_done", done, 1);
`else
    check("ror_off_data", data_out, 8'h01);
    check("ror_off_done", done, 1);
    check("ror_off_busy", busy, 0);
`endif

    issue(3'd1, 0, 8'hFF);
    sin_lsb = 1'b0;
    issue(3'd2, 5, 8'h00);
    tick(); tick();
    check("abort_mid", data_out, 8'hFC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_data", data_out, 8'h00);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 1);
    tick();
    check("abort_no_done", done, 0);

    issue(3'd1, 0, 8'h3C);
    issue(3'd2, 0, 8'h00);
    check("cnt0_data", data_out, 8'h3C);
    check("cnt0_done", done, 1);
    check("cnt0_busy", busy, 0);

    issue(3'd1, 0, 8'h0F);
    sin_lsb = 1'b1;
    cmd_valid = 1'b1; mode = 3'd2; count = 4'd4;
    tick();
    mode = 3'd1; data_in = 8'h55; count = 4'd9;
    tick(); tick(); tick();
    check("held_busy", busy, 1);
    tick();
    check("held_shift_data", data_out, 8'hFF);
    check("held_shift_done", done, 1);
    tick();
    check("held_next_load", data_out, 8'h55);
    check("held_next_done", done, 1);
    cmd_valid = 1'b0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      mode      = 3'($urandom_range(0, 7));
      count     = CW'($urandom_range(0, (1 << CW) - 1));
      data_in   = W'($urandom);
      sin_lsb   = 1'($urandom_range(0, 1));
      sin_msb   = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
